// File: rtl/sg_stream_filter.sv
// Savitzky-Golay style streaming FIR filter with frame-edge handling.
// Edges repeat the first/last full-window result; frames shorter than the window pass through scaled.
module sg_stream_filter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WIN    = 7,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned FRAC   = 14,
  localparam int unsigned AW    = $clog2(WIN),
  localparam int unsigned OUT_W = DATA_W + COEF_W + AW + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [OUT_W-1:0]         m_data,
  output logic                     m_last,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic                     busy
);

  localparam int unsigned HALF = (WIN - 1) / 2;
  localparam int unsigned CW   = $clog2(WIN + 1);
  localparam int unsigned RW   = $clog2(HALF + 2);
  localparam int unsigned PW   = COEF_W + DATA_W + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_LEAD  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_TAIL  = 3'd4;
  localparam logic [2:0] ST_SHORT = 3'd5;

  logic [2:0]               state, state_n;
  logic [CW-1:0]            cnt, cnt_n;
  logic [RW-1:0]            rep, rep_n;
  logic                     lastf, lastf_n;
  logic [DATA_W-1:0]        taps  [WIN];
  logic [DATA_W-1:0]        win_c [WIN];
  logic signed [COEF_W-1:0] coef  [WIN];
  logic signed [PW-1:0]     prod;
  logic signed [OUT_W-1:0]  acc;
  logic [DATA_W-1:0]        short_x;
  logic                     out_free;
  logic                     shift_en, out_load, out_last_n;
  logic [OUT_W-1:0]         out_data_n;
  logic                     coef_wr;

  function automatic logic signed [COEF_W-1:0] def_coef(input int k);
    if (WIN == 7) begin
      case (k)
        0, 6:    return COEF_W'(-1560);
        1, 5:    return COEF_W'(2341);
        2, 4:    return COEF_W'(4681);
        default: return COEF_W'(5461);
      endcase
    end
    return (k == int'(HALF)) ? (COEF_W'(1) << FRAC) : '0;
  endfunction

  assign out_free = !m_valid || m_ready;
  assign coef_wr  = (state == ST_IDLE) && coef_we && !s_valid && (32'(coef_addr) < WIN);

  // In RUN the MAC sees the window as it will be after the incoming sample shifts in
  always_comb begin
    for (int k = 0; k < int'(WIN) - 1; k++)
      win_c[k] = (state == ST_RUN) ? taps[k+1] : taps[k];
    win_c[WIN-1] = (state == ST_RUN) ? s_data : taps[WIN-1];
  end

  always_comb begin
    acc  = '0;
    prod = '0;
    for (int k = 0; k < int'(WIN); k++) begin
      prod = $signed({1'b0, win_c[k]}) * coef[k];
      acc  = acc + OUT_W'(prod);
    end
  end

  // Buffered samples of a short frame sit at the top of the shift register
  always_comb begin
    short_x = '0;
    for (int k = 0; k < int'(WIN); k++)
      if (CW'(int'(WIN) - k) == cnt) short_x = taps[k];
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rep_n      = rep;
    lastf_n    = lastf;
    s_ready    = 1'b0;
    shift_en   = 1'b0;
    out_load   = 1'b0;
    out_last_n = 1'b0;
    out_data_n = acc;
    case (state)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          shift_en = 1'b1;
          cnt_n    = CW'(1);
          state_n  = s_last ? ST_SHORT : ST_FILL;
        end
      end
      ST_FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          shift_en = 1'b1;
          cnt_n    = CW'(cnt + CW'(1));
          if (cnt == CW'(WIN - 1)) begin
            state_n = ST_LEAD;
            rep_n   = RW'(HALF + 1);
            lastf_n = s_last;
          end else if (s_last) begin
            state_n = ST_SHORT;
          end
        end
      end
      ST_LEAD: begin
        if (out_free) begin
          out_load = 1'b1;
          rep_n    = RW'(rep - RW'(1));
          if (rep == RW'(1)) begin
            if (lastf) begin
              state_n = ST_TAIL;
              rep_n   = RW'(HALF);
            end else begin
              state_n = ST_RUN;
            end
          end
        end
      end
      ST_RUN: begin
        s_ready = out_free;
        if (s_valid && out_free) begin
          shift_en = 1'b1;
          out_load = 1'b1;
          if (s_last) begin
            state_n = ST_TAIL;
            rep_n   = RW'(HALF);
          end
        end
      end
      ST_TAIL: begin
        if (out_free) begin
          out_load   = 1'b1;
          out_last_n = (rep == RW'(1));
          rep_n      = RW'(rep - RW'(1));
          if (rep == RW'(1)) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end
      end
      ST_SHORT: begin
        if (out_free) begin
          out_load   = 1'b1;
          out_data_n = OUT_W'(short_x) << FRAC;
          out_last_n = (cnt == CW'(1));
          cnt_n      = CW'(cnt - CW'(1));
          if (cnt == CW'(1)) state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Datapath, output register and coefficient store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      rep     <= '0;
      lastf   <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      busy    <= 1'b0;
      for (int k = 0; k < int'(WIN); k++) begin
        taps[k] <= '0;
        coef[k] <= def_coef(k);
      end
    end else begin
      cnt   <= cnt_n;
      rep   <= rep_n;
      lastf <= lastf_n;
      busy  <= (state_n != ST_IDLE);
      if (shift_en) begin
        for (int k = 0; k < int'(WIN) - 1; k++) taps[k] <= taps[k+1];
        taps[WIN-1] <= s_data;
      end
      if (out_load) begin
        m_valid <= 1'b1;
        m_data  <= out_data_n;
        m_last  <= out_last_n;
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      if (coef_wr) coef[coef_addr] <= coef_wdata;
    end
  end

endmodule

// File: tb/tb_sg_stream_filter.sv
// Directed bench for sg_stream_filter: record k of the table is input sample k and output beat k.
module tb_sg_stream_filter;

  localparam int NV = 76;

  typedef struct {
    logic [7:0] x;
    logic       last;
    longint     y;
    logic       ylast;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, s_last;
  logic [7:0]  s_data;
  logic        m_valid, m_ready, m_last;
  logic [27:0] m_data;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        busy;

  vec_t tab [NV];
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  sg_stream_filter dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .busy(busy)
  );

  task automatic chk(input string name, input int idx, input longint got, input longint exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic set(input int i, input int x, input logic l, input longint y, input logic yl);
    tab[i].x = 8'(x); tab[i].last = l; tab[i].y = y; tab[i].ylast = yl;
  endtask

  // stall: m_ready pattern 1,0,0,1; wr: attempt a coef write while the frame is in flight
  task automatic run(input int first, input int n, input bit stall, input bit wr);
    int     in_i = first;
    int     out_i = first;
    int     cyc = 0;
    bit     held = 0;
    longint hval = 0;
    while (out_i < first + n && cyc < 2000) begin
      @(negedge clk);
      m_ready    = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      coef_we    = wr && cyc >= 8 && cyc <= 14;
      coef_addr  = 3'd3;
      coef_wdata = 16'd0;
      if (in_i < first + n) begin
        s_valid = 1'b1; s_data = tab[in_i].x; s_last = tab[in_i].last;
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      #1;
      if (held) begin
        chk("hold_valid", out_i, longint'(m_valid), 1);
        chk("hold_data", out_i, $signed(m_data), hval);
      end
      if (s_valid && s_ready) in_i++;
      held = m_valid && !m_ready;
      hval = $signed(m_data);
      if (m_valid && m_ready) begin
        chk("data", out_i, $signed(m_data), tab[out_i].y);
        chk("last", out_i, longint'(m_last), longint'(tab[out_i].ylast));
        out_i++;
      end
      cyc++;
    end
    s_valid = 1'b0; s_last = 1'b0; coef_we = 1'b0; m_ready = 1'b1;
    if (cyc >= 2000) chk("timeout", first, longint'(out_i), longint'(first + n));
    repeat (4) @(negedge clk);
    #1 chk("no_extra", first, longint'(m_valid), 0);
  endtask

  task automatic wr_coef(input int a, input int d);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 3'(a); coef_wdata = 16'(d);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 20; i++) set(i, 100, i == 19, 1638500, i == 19);
    for (int j = 0; j < 16; j++)
      set(20 + j, j, j == 15, (j <= 3) ? 49155 : (j >= 13) ? 196620 : longint'(j) * 16385, j == 15);
    set(36, 5, 0, 81920, 0);
    set(37, 9, 0, 147456, 0);
    set(38, 2, 1, 32768, 1);
    for (int i = 0; i < 20; i++) set(39 + i, 100, i == 19, 1638500, i == 19);
    begin
      int ex [10] = '{4, 4, 4, 4, 5, 6, 7, 7, 7, 7};
      for (int i = 0; i < 10; i++) set(59 + i, i + 1, i == 9, longint'(ex[i]) << 14, i == 9);
    end
    for (int i = 0; i < 7; i++) set(69 + i, 10, i == 6, 163850, i == 6);

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_m_valid", 0, longint'(m_valid), 0);
    chk("rst_m_data", 0, longint'(m_data), 0);
    chk("rst_busy", 0, longint'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_s_ready", 0, longint'(s_ready), 1);

    run(0, 39, 0, 0);
    run(39, 20, 1, 0);

    for (int a = 0; a < 7; a++) wr_coef(a, (a == 3) ? 16384 : 0);
    wr_coef(7, 12345);
    run(59, 10, 0, 1);

    // Reset in the middle of a RUN phase drops the frame and the custom coefficients
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 8'd100; s_last = 1'b0; m_ready = 1'b1;
    end
    #1;
    chk("mid_busy", 0, longint'(busy), 1);
    chk("mid_m_valid", 0, longint'(m_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", 0, longint'(m_valid), 0);
    chk("arst_m_data", 0, longint'(m_data), 0);
    chk("arst_m_last", 0, longint'(m_last), 0);
    chk("arst_busy", 0, longint'(busy), 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("post_rst_idle", 0, longint'(m_valid), 0);
    run(69, 7, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/sg_stream_filter.md
SG_STREAM_FILTER -- requirements
Module: sg_stream_filter

Interface
REQ-001 Parameter DATA_W, default 8, width of each unsigned input sample.
REQ-002 Parameter WIN, default 7, window length; odd, 3..15; HALF = (WIN-1)/2.
REQ-003 Parameter COEF_W, default 16, signed coefficient width.
REQ-004 Parameter FRAC, default 14, coefficient fractional bits; OUT_W = DATA_W+COEF_W+clog2(WIN)+1.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 s_valid/s_ready/s_data[DATA_W]/s_last  in/out/in/in  input sample stream; s_last marks the final frame sample.
REQ-008 m_valid/m_ready/m_data[OUT_W]/m_last  out/in/out/out  output stream; m_data is signed, FRAC fractional bits.
REQ-009 coef_we/coef_addr[clog2(WIN)]/coef_wdata[COEF_W]  in  coefficient write port.
REQ-010 busy  out  1  high in every state except IDLE.

Function
REQ-011 A transfer occurs on a cycle with valid and ready both high; m_data/m_last shall hold stable while m_valid && !m_ready.
REQ-012 Window: WIN-deep shift register; tap k multiplies coef[k], tap 0 = oldest sample; y = signed sum of coef[k]*x[k] at full OUT_W precision, no rounding or saturation.
REQ-013 States: IDLE, FILL, LEAD, RUN, TAIL, SHORT.
REQ-014 IDLE: s_ready=1; accepting a sample loads tap WIN-1, cnt=1, -> FILL (-> SHORT if s_last).
REQ-015 FILL: s_ready=1, m_valid=0; each accepted sample shifts in, cnt++; on cnt reaching WIN compute y -> LEAD; s_last with cnt<WIN -> SHORT.
REQ-016 LEAD: s_ready=0; emit the first y HALF+1 times (output indices 0..HALF); then -> RUN, or -> TAIL if s_last arrived with sample WIN.
REQ-017 RUN: s_ready = !m_valid || m_ready; each accepted sample shifts and yields a new y, presented on m_valid the next cycle (latency 1); accepted s_last -> TAIL after that output.
REQ-018 TAIL: s_ready=0; emit the last y HALF more times; final beat carries m_last=1; then -> IDLE.
REQ-019 SHORT (frame length L<WIN): s_ready=0; emit the L buffered samples oldest-first as x<<FRAC, m_last on the L-th; then -> IDLE.
REQ-020 Output count per frame shall equal input count for every L>=1.
REQ-021 Coefficient writes take effect only in IDLE and when no input is accepted the same cycle; writes in other states are ignored; coef_addr>=WIN is ignored.
REQ-022 m_last shall be 0 on every beat except the final beat of a frame.

Reset
REQ-023 rst_n low shall asynchronously force IDLE, cnt=0, taps=0, m_valid=0, m_last=0, m_data=0, busy=0; s_ready=1 once released.
REQ-024 Reset coefficients for WIN=7: -1560, 2341, 4681, 5461, 4681, 2341, -1560 (Q14 of -2,3,6,7,6,3,-2 /21); other WIN: all 0 except coef[HALF] = 1<<FRAC.
REQ-025 Reset mid-frame shall drop the frame with no further output; the next frame starts in IDLE.
REQ-026 Coefficient writes made before reset shall be lost.

Verification
REQ-027 Default coefs, 20-sample frame of constant 100, m_ready=1 -> 20 outputs, each 1638500, m_last on beat 20 only.
REQ-028 Ramp x=i, i=0..15 -> output j=3..12 equals j*16385; outputs 0..2 equal 49155; outputs 13..15 equal 196620.
REQ-029 3-sample frame 5,9,2 -> outputs 81920, 147456, 32768, m_last on third, SHORT path taken.
REQ-030 Constant-100 frame with m_ready toggling 1,0,0,1 -> no lost or duplicated beats, m_data stable while stalled, 20 outputs.
REQ-031 Write coef[3]=16384, all others 0, in IDLE; then frame 1..10 -> outputs 4,4,4,4,5,6,7,7,7,7 (each <<14); coef write during RUN ignored.
REQ-032 Assert rst_n low during RUN of frame 1 -> m_valid drops immediately; next 7-sample frame of constant 10 -> 7 outputs of 163850.
